// File: rtl/sd_defines.sv
// Shared constants and types for the SD transmit-path blocks.
package sd_defines;

    localparam int SD_BUS_W      = 32;
    localparam int SD_MEM_OFFSET = 4;
    localparam int SD_FIFO_AW    = 3;
    localparam int SD_FIFO_DEPTH = 1 << SD_FIFO_AW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_PUSH = 2'd2
    } fill_state_t;

endpackage

// File: rtl/sd_fifo_tx_filler_if.sv
// Wishbone master bus used by the TX filler to fetch block data.
interface sd_fifo_tx_filler_if;
    import sd_defines::*;

    logic [SD_BUS_W-1:0] m_wb_adr_o;
    logic [SD_BUS_W-1:0] m_wb_dat_i;
    logic                m_wb_we_o;
    logic                m_wb_cyc_o;
    logic                m_wb_stb_o;
    logic                m_wb_ack_i;
    logic [2:0]          m_wb_cti_o;
    logic [1:0]          m_wb_bte_o;

    modport master (
        output m_wb_adr_o, m_wb_we_o, m_wb_cyc_o, m_wb_stb_o, m_wb_cti_o, m_wb_bte_o,
        input  m_wb_dat_i, m_wb_ack_i
    );

    modport slave (
        input  m_wb_adr_o, m_wb_we_o, m_wb_cyc_o, m_wb_stb_o, m_wb_cti_o, m_wb_bte_o,
        output m_wb_dat_i, m_wb_ack_i
    );

endinterface

// File: rtl/sd_fifo_tx_filler_fifo.sv
// Dual-clock first-word-fall-through FIFO: write on wclk, read on rclk,
// Gray pointers crossing through 2-flop synchronizers.
module sd_tx_fifo
    import sd_defines::*;
#(
    parameter int AW = SD_FIFO_AW,
    parameter int DW = SD_BUS_W
) (
    input  logic          wclk,
    input  logic          rst,
    input  logic          wr,
    input  logic [DW-1:0] wdat,
    output logic          full,
    input  logic          rclk,
    input  logic          rd,
    output logic [DW-1:0] rdat,
    output logic          empty
);
    localparam int DEPTH = 1 << AW;

    function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wbin, wgray, rq1, rq2, wbin_nxt;
    logic [AW:0]   rbin, rgray, wq1, wq2, rbin_nxt;
    logic          rrst_q1, rrst;

    assign wbin_nxt = wbin + {{AW{1'b0}}, (wr & ~full)};
    assign full     = (wgray == {~rq2[AW:AW-1], rq2[AW-2:0]});

    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            wbin  <= '0;
            wgray <= '0;
            rq1   <= '0;
            rq2   <= '0;
        end else begin
            wbin  <= wbin_nxt;
            wgray <= bin2gray(wbin_nxt);
            rq1   <= rgray;
            rq2   <= rq1;
        end
    end

    always_ff @(posedge wclk) begin
        if (wr && !full)
            mem[wbin[AW-1:0]] <= wdat;
    end

    // Reset asserts asynchronously but is released in step with rclk.
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) {rrst, rrst_q1} <= 2'b11;
        else     {rrst, rrst_q1} <= {rrst_q1, 1'b0};
    end

    assign rbin_nxt = rbin + {{AW{1'b0}}, (rd & ~empty)};
    assign empty    = (rgray == wq2);
    assign rdat     = mem[rbin[AW-1:0]];

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rbin  <= '0;
            rgray <= '0;
            wq1   <= '0;
            wq2   <= '0;
        end else begin
            rbin  <= rbin_nxt;
            rgray <= bin2gray(rbin_nxt);
            wq1   <= wgray;
            wq2   <= wq1;
        end
    end

endmodule

// File: rtl/sd_fifo_tx_filler.sv
// Fetches block data word by word over Wishbone and pushes it into a
// dual-clock TX FIFO drained by the SD serial side.
module sd_fifo_tx_filler
    import sd_defines::*;
#(
    parameter int FIFO_AW    = SD_FIFO_AW,
    parameter int MEM_OFFSET = SD_MEM_OFFSET
) (
    input  logic                clk,
    input  logic                rst,
    sd_fifo_tx_filler_if.master wb,
    input  logic                en,
    input  logic [SD_BUS_W-1:0] adr,
    input  logic                sd_clk,
    input  logic                rd,
    output logic [SD_BUS_W-1:0] dat_o,
    output logic                empty
);
    fill_state_t         state, state_nxt;
    logic [8:0]          offset;
    logic [SD_BUS_W-1:0] dat_q;
    logic                cyc_stb, fifo_wr, fifo_rst, full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Full is only sampled in IDLE, after the previous push has settled.
    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (!full) state_nxt = ST_BUS;
                ST_BUS:  if (wb.m_wb_ack_i) state_nxt = ST_PUSH;
                ST_PUSH: state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cyc_stb = 1'b0;
        fifo_wr = 1'b0;
        case (state)
            ST_BUS:  cyc_stb = 1'b1;
            ST_PUSH: fifo_wr = en;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            offset   <= '0;
            dat_q    <= '0;
            fifo_rst <= 1'b1;
        end else begin
            fifo_rst <= ~en;
            if (!en)
                offset <= '0;
            else if (state == ST_PUSH)
                offset <= offset + 9'(MEM_OFFSET);
            if (en && state == ST_BUS && wb.m_wb_ack_i)
                dat_q <= wb.m_wb_dat_i;
        end
    end

    assign wb.m_wb_adr_o = adr + {{(SD_BUS_W-9){1'b0}}, offset};
    assign wb.m_wb_cyc_o = cyc_stb;
    assign wb.m_wb_stb_o = cyc_stb;
    assign wb.m_wb_we_o  = 1'b0;
    assign wb.m_wb_cti_o = 3'b000;
    assign wb.m_wb_bte_o = 2'b00;

    sd_tx_fifo #(
        .AW (FIFO_AW),
        .DW (SD_BUS_W)
    ) u_fifo (
        .wclk  (clk),
        .rst   (fifo_rst),
        .wr    (fifo_wr),
        .wdat  (dat_q),
        .full  (full),
        .rclk  (sd_clk),
        .rd    (rd),
        .rdat  (dat_o),
        .empty (empty)
    );

endmodule

// File: tb/tb_sd_fifo_tx_filler.sv
// Directed bench for sd_fifo_tx_filler with a small Wishbone slave model.
module tb_sd_fifo_tx_filler;

    logic        clk = 1'b0;
    logic        sd_clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        rd = 1'b0;
    logic [31:0] adr = 32'h0;
    logic [31:0] dat_o;
    logic        empty;

    sd_fifo_tx_filler_if wb();

    sd_fifo_tx_filler dut (
        .clk    (clk),
        .rst    (rst),
        .wb     (wb),
        .en     (en),
        .adr    (adr),
        .sd_clk (sd_clk),
        .rd     (rd),
        .dat_o  (dat_o),
        .empty  (empty)
    );

    always #5 clk = ~clk;
    always #6 sd_clk = ~sd_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Slave model: acks ack_dly cycles after it first sees cyc/stb, logs the address.
    bit          slave_on = 1'b0;
    bit          drain_on = 1'b0;
    int          ack_dly  = 0;
    int          wait_cnt = 0;
    int          n_acks   = 0;
    logic [31:0] data_base = 32'h0;
    logic [31:0] adr_log[$];

    always @(negedge clk) begin
        if (slave_on) begin
            if (wb.m_wb_cyc_o && wb.m_wb_stb_o && !wb.m_wb_ack_i) begin
                if (wait_cnt >= ack_dly) begin
                    wb.m_wb_ack_i = 1'b1;
                    wb.m_wb_dat_i = data_base + n_acks;
                    adr_log.push_back(wb.m_wb_adr_o);
                    n_acks++;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wb.m_wb_ack_i = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    always @(negedge sd_clk) begin
        if (drain_on) rd = !empty;
    end

    task automatic slave_cfg(input int dly, input logic [31:0] base);
        ack_dly   = dly;
        data_base = base;
        n_acks    = 0;
        wait_cnt  = 0;
        adr_log.delete();
    endtask

    task automatic wait_acks(input int target, input int budget, input string tag);
        int c;
        c = 0;
        while (n_acks < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(tag, n_acks >= target, 1);
    endtask

    task automatic wait_cyc(input string tag);
        int c;
        c = 0;
        while (!wb.m_wb_cyc_o && c < 20) begin
            @(negedge clk);
            c++;
        end
        check(tag, wb.m_wb_cyc_o, 1);
    endtask

    task automatic wait_not_empty(input string tag);
        int c;
        c = 0;
        while (empty && c < 20) begin
            @(negedge sd_clk);
            c++;
        end
        check(tag, empty, 0);
    endtask

    int res_n;
    bit stable;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        wb.m_wb_ack_i = 1'b0;
        wb.m_wb_dat_i = 32'h0;
        adr = 32'h1234;
        repeat (2) @(negedge clk);

        check("rst_cyc",   wb.m_wb_cyc_o, 0);
        check("rst_stb",   wb.m_wb_stb_o, 0);
        check("rst_we",    wb.m_wb_we_o, 0);
        check("rst_cti",   wb.m_wb_cti_o, 0);
        check("rst_bte",   wb.m_wb_bte_o, 0);
        check("rst_empty", empty, 1);
        check("rst_adr",   wb.m_wb_adr_o, 32'h1234);

        // basic fill
        rst = 1'b0;
        adr = 32'h1000;
        slave_cfg(1, 32'hA0);
        slave_on = 1'b1;
        en = 1'b1;
        wait_acks(8, 300, "fill_acks_reached");
        repeat (30) @(negedge clk);
        check("fill_no_9th_cyc", wb.m_wb_cyc_o, 0);
        check("fill_ack_count",  n_acks, 8);
        check("fill_not_empty",  empty, 0);
        check("fill_we",         wb.m_wb_we_o, 0);
        for (int i = 0; i < 8; i++)
            check($sformatf("fill_adr%0d", i), adr_log[i], 32'h1000 + 4 * i);

        // drain with the slave silent, so a resumed request stays in BUS
        slave_on = 1'b0;
        wb.m_wb_ack_i = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    @(negedge sd_clk);
                    check($sformatf("drain_dat%0d", i), dat_o, 32'hA0 + i);
                    rd = 1'b1;
                end
                @(negedge sd_clk);
                rd = 1'b0;
                check("drain_empty", empty, 1);
            end
            begin
                res_n = 0;
                wait (rd);
                @(posedge sd_clk);
                while (res_n < 6 && !wb.m_wb_cyc_o) begin
                    @(posedge clk);
                    res_n++;
                    #1;
                end
                check("drain_resume_3clk", (wb.m_wb_cyc_o && res_n <= 3), 1);
            end
        join

        // abort while in BUS, then a late ack outside BUS
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
        check("abort_cyc",   wb.m_wb_cyc_o, 0);
        check("abort_stb",   wb.m_wb_stb_o, 0);
        check("abort_empty", empty, 1);
        @(negedge clk);
        wb.m_wb_ack_i = 1'b1;
        wb.m_wb_dat_i = 32'hDEAD_BEEF;
        en = 1'b1;
        @(negedge clk);
        wb.m_wb_ack_i = 1'b0;
        slave_cfg(0, 32'hB0);
        slave_on = 1'b1;
        wait_acks(1, 50, "abort_reacq");
        check("abort_next_adr", adr_log[0], 32'h1000);
        wait_not_empty("abort_fill");
        check("abort_head", dat_o, 32'hB0);
        en = 1'b0;

        // wrap of the 9-bit offset with continuous draining
        repeat (3) @(negedge clk);
        adr = 32'h2000;
        slave_cfg(0, 32'h0);
        drain_on = 1'b1;
        en = 1'b1;
        wait_acks(129, 2000, "wrap_acks_reached");
        en = 1'b0;
        drain_on = 1'b0;
        @(negedge sd_clk);
        rd = 1'b0;
        check("wrap_adr0",   adr_log[0],   32'h2000);
        check("wrap_adr1",   adr_log[1],   32'h2004);
        check("wrap_adr127", adr_log[127], 32'h21FC);
        check("wrap_adr128", adr_log[128], 32'h2000);

        // slow slave
        repeat (3) @(negedge clk);
        adr = 32'h4000;
        slave_cfg(20, 32'hC0);
        en = 1'b1;
        wait_cyc("slow_req");
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!(wb.m_wb_adr_o == 32'h4000 && wb.m_wb_cyc_o && wb.m_wb_stb_o)) stable = 1'b0;
        end
        check("slow_stable", stable, 1);
        wait_acks(1, 20, "slow_ack");
        wait_not_empty("slow_push");
        check("slow_head", dat_o, 32'hC0);
        @(negedge sd_clk);
        rd = 1'b1;
        @(negedge sd_clk);
        rd = 1'b0;
        check("slow_one_write", empty, 1);
        check("slow_ack_count", n_acks, 1);
        en = 1'b0;

        // asynchronous reset in the middle of PUSH
        repeat (3) @(negedge clk);
        slave_on = 1'b0;
        wb.m_wb_ack_i = 1'b0;
        adr = 32'h5000;
        en = 1'b1;
        wait_cyc("arst_req");
        @(negedge clk);
        wb.m_wb_ack_i = 1'b1;
        wb.m_wb_dat_i = 32'h55;
        @(posedge clk);
        #2;
        rst = 1'b1;
        wb.m_wb_ack_i = 1'b0;
        #1;
        check("arst_cyc",   wb.m_wb_cyc_o, 0);
        check("arst_stb",   wb.m_wb_stb_o, 0);
        check("arst_we",    wb.m_wb_we_o, 0);
        check("arst_empty", empty, 1);
        check("arst_adr",   wb.m_wb_adr_o, 32'h5000);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge sd_clk);
        check("arst_no_write", empty, 1);
        check("arst_rereq",    wb.m_wb_cyc_o, 1);
        check("arst_rereq_adr", wb.m_wb_adr_o, 32'h5000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sd_fifo_tx_filler.md
SD_FIFO_TX_FILLER -- requirements
Module: sd_fifo_tx_filler

Interface
REQ-001 SHALL have parameter FIFO_AW, default 3, meaning TX FIFO address width (depth 2**FIFO_AW = 8 words).
REQ-002 SHALL have parameter MEM_OFFSET, default 4, meaning byte increment of the offset per word fetched.
REQ-003 SHALL have port clk  input  1  system/Wishbone clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port m_wb_adr_o  output  32  master address, equal to adr + offset.
REQ-006 SHALL have port m_wb_dat_i  input  32  master read data.
REQ-007 SHALL have ports m_wb_we_o, m_wb_cyc_o, m_wb_stb_o  output  1 each  Wishbone master controls.
REQ-008 SHALL have port m_wb_ack_i  input  1  slave acknowledge.
REQ-009 SHALL have ports m_wb_cti_o  output  3 and m_wb_bte_o  output  2  burst tags.
REQ-010 SHALL have port en  input  1  fill enable; low means abort and flush.
REQ-011 SHALL have port adr  input  32  base byte address of the block.
REQ-012 SHALL have port sd_clk  input  1  serial-side read clock.
REQ-013 SHALL have port rd  input  1  serial-side FIFO pop, sampled on sd_clk.
REQ-014 SHALL have port dat_o  output  32  FIFO head word, valid while empty=0.
REQ-015 SHALL have port empty  output  1  FIFO empty, in the sd_clk domain.

Function
REQ-016 SHALL be single Wishbone-read only: m_wb_we_o=0, m_wb_cti_o=000 and m_wb_bte_o=00 at all times.
REQ-017 SHALL implement the FSM states IDLE, BUS and PUSH, all registered on clk.
REQ-018 IDLE: when en=1 and fifo full=0, SHALL go to BUS and assert cyc/stb on the next edge.
REQ-019 BUS: SHALL hold cyc/stb=1 and the address stable until m_wb_ack_i=1; on the ack edge it SHALL capture m_wb_dat_i, clear cyc/stb and go to PUSH.
REQ-020 PUSH: SHALL assert the FIFO write for exactly one clk cycle with the captured word, add MEM_OFFSET to offset, and return to IDLE.
REQ-021 SHALL never issue a new request before full has been re-evaluated after the previous push, so the FIFO never overflows.
REQ-022 offset SHALL be 9 bits, unsigned, and wrap modulo 512 (508+4 gives 0); m_wb_adr_o SHALL be the 32-bit sum adr + zero-extended offset.
REQ-023 SHALL ignore m_wb_ack_i outside BUS.
REQ-024 en=0 in any state SHALL clear cyc/stb on the next edge, drop any in-flight ack, set offset to 0, go to IDLE and hold the FIFO in reset.
REQ-025 The FIFO SHALL be dual-clock with write on clk and read on sd_clk, using Gray-coded pointers and 2-flop synchronizers.
REQ-026 full SHALL assert on the clk edge of the write that fills the FIFO, and SHALL deassert within 3 clk edges after a pop.
REQ-027 empty SHALL assert on the sd_clk edge of the pop that drains the FIFO, and SHALL deassert within 3 sd_clk edges after a push.
REQ-028 rd while empty=1 SHALL be ignored, with no pointer change.
REQ-029 dat_o SHALL present the head word combinationally from the read pointer (first-word-fall-through).

Reset
REQ-030 rst=1 SHALL force state IDLE, cyc/stb/we=0, offset=0, captured data=0, FIFO write=0 and FIFO reset=1.
REQ-031 The internal FIFO reset SHALL be registered: 1 while en=0 or rst=1, and 0 one clk after en rises.
REQ-032 After reset, empty SHALL read 1 and full SHALL read 0.

Structure
REQ-033 MEM_OFFSET, SD_BUS_W and the FIFO depth constant SHALL live in the shared sd_defines package/header.
REQ-034 The dual-clock FIFO SHALL be one sub-module, sd_tx_fifo, instantiated once; the FSM and offset logic SHALL stay in sd_fifo_tx_filler.

Verification
REQ-035 Test "basic fill": adr=0x1000, en=1, slave acks 1 cycle after stb, returning 0xA0..0xA7 -> reads at 0x1000..0x101C; the FIFO fills; full=1 and no 9th request is issued.
REQ-036 Test "drain": after the basic fill, pop 8 words on sd_clk at a rate unrelated to clk -> dat_o is 0xA0..0xA7 in order; empty=1 after the 8th pop; filling resumes within 3 clk after the first pop.
REQ-037 Test "wrap": with reads continuously drained, 129 reads with adr=0x2000 -> the 128th read is at 0x21FC and the 129th at 0x2000.
REQ-038 Test "abort": drop en while in BUS with the ack delayed 5 cycles -> cyc/stb=0 next edge; the late ack is ignored; empty=1; the next read is at adr+0.
REQ-039 Test "async reset": assert rst mid-PUSH -> all outputs reach reset values with no clk edge; no FIFO write occurs.
REQ-040 Test "slow slave": hold ack low for 20 cycles -> address, cyc and stb stay stable throughout; exactly one FIFO write follows the ack.
